alu_cmd_sequencer: RTL and testbench

//  - Command-side initiator for the 8-bit ALU (opcode[2:0], a/b in, result/flags out).
//  - Accepts register-level commands over a valid/ready handshake and holds a small register file.
//  - Reads the register file to drive the ALU, captures result and flags, and writes back.
//  - Sits between a test/control master and the combinational ALU instance.

---
 rtl/alu_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Register-file command sequencer driving an external combinational 8-bit ALU.
// Optional conditional execution (skip when Z set) is enabled by ALU_SEQ_COND_EXEC_EN.
module alu_cmd_sequencer #(
  parameter int unsigned NREG = 4,
  parameter int unsigned RA_W = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_opcode,
  input  logic [RA_W-1:0] cmd_src_a,
  input  logic [RA_W-1:0] cmd_src_b,
  input  logic [RA_W-1:0] cmd_dst,
  input  logic            cmd_imm_en,
  input  logic [7:0]      cmd_imm,
`ifdef ALU_SEQ_COND_EXEC_EN
  input  logic            cmd_cond,
`endif
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [2:0]      alu_opcode,
  input  logic [7:0]      alu_result,
  input  logic [3:0]      alu_flags,
  output logic            done,
  output logic            done_err,
  output logic [7:0]      wb_data,
  output logic [3:0]      flags_q
);

  localparam int unsigned DW = 8;
  localparam int unsigned FW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   rf_q [NREG];
  logic [DW-1:0]   rf_d [NREG];
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [RA_W-1:0] dst_q, dst_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [DW-1:0]   wb_q, wb_d;
  logic [FW-1:0]   flags_d;
  logic            skip_c;

`ifdef ALU_SEQ_COND_EXEC_EN
  logic skip_q, skip_d;
  assign skip_c = skip_q;
`else
  assign skip_c = 1'b0;
`endif

  // Next-state, register-file write and output staging
  always_comb begin
    state_d  = state_q;
    rf_d     = rf_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    dst_d    = dst_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wb_d     = wb_q;
    flags_d  = flags_q;
`ifdef ALU_SEQ_COND_EXEC_EN
    skip_d   = skip_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          alu_a_d  = rf_q[cmd_src_a];
          alu_b_d  = cmd_imm_en ? cmd_imm : rf_q[cmd_src_b];
          alu_op_d = cmd_opcode;
          dst_d    = cmd_dst;
`ifdef ALU_SEQ_COND_EXEC_EN
          skip_d   = cmd_cond && flags_q[0];
`endif
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        // ALU result is captured here so writeback and done are visible in WB
        done_d  = 1'b1;
        state_d = S_WB;
        if (alu_op_q[2:1] == 2'b11) begin
          err_d = 1'b1;
        end else if (!skip_c) begin
          rf_d[dst_q] = alu_result;
          flags_d     = alu_flags;
          wb_d        = alu_result;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      dst_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wb_q     <= '0;
      flags_q  <= '0;
`ifdef ALU_SEQ_COND_EXEC_EN
      skip_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rf_q     <= rf_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      dst_q    <= dst_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wb_q     <= wb_d;
      flags_q  <= flags_d;
`ifdef ALU_SEQ_COND_EXEC_EN
      skip_q   <= skip_d;
`endif
    end
  end

  assign cmd_ready  = ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign done       = done_q;
  assign done_err   = err_q;
  assign wb_data    = wb_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a stub ALU and a register-file reference model.
module tb_alu_cmd_sequencer;

`ifdef ALU_SEQ_COND_EXEC_EN
  localparam bit COND_BUILD = 1'b1;
`else
  localparam bit COND_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_opcode = '0;
  logic [1:0] cmd_src_a = '0;
  logic [1:0] cmd_src_b = '0;
  logic [1:0] cmd_dst = '0;
  logic       cmd_imm_en = 1'b0;
  logic [7:0] cmd_imm = '0;
  logic       cmd_cond = 1'b0;
  logic [7:0] alu_a, alu_b, alu_result, wb_data;
  logic [2:0] alu_opcode;
  logic [3:0] alu_flags, flags_q;
  logic       done, done_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] m_rf [4];
  logic [3:0] m_flags;
  logic [7:0] m_wb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub ALU: returns {V,N,C,Z, result}
  function automatic logic [11:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic v, c;
    s = '0; r = '0; v = 1'b0; c = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      default: r = '0;
    endcase
    return {v, r[7], c, (r == 8'd0), r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);

  alu_cmd_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_src_a  (cmd_src_a),
    .cmd_src_b  (cmd_src_b),
    .cmd_dst    (cmd_dst),
    .cmd_imm_en (cmd_imm_en),
    .cmd_imm    (cmd_imm),
`ifdef ALU_SEQ_COND_EXEC_EN
    .cmd_cond   (cmd_cond),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .done       (done),
    .done_err   (done_err),
    .wb_data    (wb_data),
    .flags_q    (flags_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_flags = 4'h0;
    m_wb    = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alu_a"}, 32'(alu_a), 32'h0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'h0);
    check({tag, "_alu_op"}, 32'(alu_opcode), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_done_err"}, 32'(done_err), 32'h0);
    check({tag, "_wb_data"}, 32'(wb_data), 32'h0);
    check({tag, "_flags"}, 32'(flags_q), 32'h0);
  endtask

  // Issue one command starting at a negedge; returns at the negedge after WB
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [1:0] dst, input logic ie, input logic [7:0] imm,
                         input logic cond, input bit hold, output int acc);
    logic [7:0] ea, eb;
    logic [11:0] fr;
    logic skip, bad;
    int k;
    cmd_opcode = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = dst;
    cmd_imm_en = ie; cmd_imm = imm; cmd_cond = cond; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 8) begin @(negedge clk); k++; end
    check("accept_ready", 32'(cmd_ready), 32'h1);
    ea   = m_rf[sa];
    eb   = ie ? imm : m_rf[sb];
    fr   = alu_fn(op, ea, eb);
    bad  = (op >= 3'd6);
    skip = COND_BUILD && cond && m_flags[0];
    @(posedge clk);
    #1 if (!hold) cmd_valid = 1'b0;
    @(negedge clk);
    acc = cyc;
    check("exec_ready", 32'(cmd_ready), 32'h0);
    check("exec_done", 32'(done), 32'h0);
    check("exec_alu_a", 32'(alu_a), 32'(ea));
    check("exec_alu_b", 32'(alu_b), 32'(eb));
    check("exec_alu_op", 32'(alu_opcode), 32'(op));
    @(negedge clk);
    if (!bad && !skip) begin
      m_rf[dst] = fr[7:0];
      m_flags   = fr[11:8];
      m_wb      = fr[7:0];
    end
    check("wb_done", 32'(done), 32'h1);
    check("wb_done_err", 32'(done_err), 32'(bad));
    check("wb_ready", 32'(cmd_ready), 32'h0);
    check("wb_data", 32'(wb_data), 32'(m_wb));
    check("wb_flags", 32'(flags_q), 32'(m_flags));
    @(negedge clk);
    check("post_done", 32'(done), 32'h0);
    check("post_ready", 32'(cmd_ready), 32'h1);
  endtask

  initial begin
    int a0, a1, a2;
    model_reset();
    // Reset and idle: no done, reset outputs
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_done", 32'(done), 32'h0);
      check("idle_ready", 32'(cmd_ready), 32'h1);
    end
    check_reset_outputs("idle");

    // Directed: OR R1,R0,#7F ; ADD R2,R1,#01 -> 0x80, V N
    run_cmd(3'd3, 2'd0, 2'd0, 2'd1, 1'b1, 8'h7F, 1'b0, 1'b0, a0);
    check("or_wb", 32'(wb_data), 32'h7F);
    run_cmd(3'd0, 2'd1, 2'd0, 2'd2, 1'b1, 8'h01, 1'b0, 1'b0, a0);
    check("add_wb", 32'(wb_data), 32'h80);
    check("add_flags", 32'(flags_q), 32'hC);
    // XOR R1,R1,R1 -> 0, Z
    run_cmd(3'd4, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, a0);
    check("xor_wb", 32'(wb_data), 32'h00);
    check("xor_flags", 32'(flags_q), 32'h1);
    // Invalid opcode into R2: no write, flags kept
    run_cmd(3'd6, 2'd0, 2'd0, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0, a0);
    check("inv_flags", 32'(flags_q), 32'h1);
    // Read back R2 and R1 through operand paths
    run_cmd(3'd2, 2'd2, 2'd1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, a0);
    check("r2_kept", 32'(alu_a), 32'h80);
    // Conditional skip while Z=1 (only skips in the conditional build)
    check("z_before_cond", 32'(flags_q[0]), 32'h1);
    run_cmd(3'd0, 2'd2, 2'd2, 2'd3, 1'b1, 8'h05, 1'b1, 1'b0, a0);

    // Back-to-back with cmd_valid held high
    run_cmd(3'd0, 2'd2, 2'd0, 2'd3, 1'b1, 8'h11, 1'b0, 1'b1, a0);
    run_cmd(3'd1, 2'd3, 2'd2, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, a1);
    run_cmd(3'd5, 2'd0, 2'd3, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, a2);
    check("b2b_gap1", 32'(a1 - a0), 32'd3);
    check("b2b_gap2", 32'(a2 - a1), 32'd3);

    // Randomized commands against the model
    for (int n = 0; n < 40; n++) begin
      run_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a0);
    end

    // Reset asserted during EXEC of ADD R3
    cmd_opcode = 3'd0; cmd_src_a = 2'd1; cmd_dst = 2'd3; cmd_imm_en = 1'b1;
    cmd_imm = 8'h42; cmd_cond = 1'b0; cmd_valid = 1'b1;
    for (int k = 0; k < 8 && !cmd_ready; k++) @(negedge clk);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    check("mid_reset_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_done", 32'(done), 32'h0);
    end
    run_cmd(3'd3, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, a0);
    check("r3_after_reset", 32'(alu_a), 32'h00);
    for (int n = 0; n < 10; n++) begin
      run_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 1)), 1'b0, a0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
